// File: rtl/gen_pipe_arb_if.sv
// Bundle for the requester side, the shared-pipe side and the response side of gen_pipe_arb.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface gen_pipe_arb_if #(
  parameter int NREQ  = 4,
  parameter int DAT_W = 8,
  parameter int ID_W  = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_vld;
  logic [NREQ*DAT_W-1:0] req_dat;
  logic [NREQ-1:0]       req_rdy;
  logic [DAT_W-1:0]      pipe_dat_o;
  logic                  pipe_vld_o;
  logic [DAT_W-1:0]      pipe_dat_i;
  logic                  pipe_vld_i;
  logic [NREQ-1:0]       rsp_vld;
  logic [DAT_W-1:0]      rsp_dat;
  logic [ID_W-1:0]       rsp_id;
  logic                  err_seq;

  modport slave (
    input  req_vld, req_dat, pipe_dat_i, pipe_vld_i,
    output req_rdy, pipe_dat_o, pipe_vld_o, rsp_vld, rsp_dat, rsp_id, err_seq
  );

  modport master (
    output req_vld, req_dat, pipe_dat_i, pipe_vld_i,
    input  req_rdy, pipe_dat_o, pipe_vld_o, rsp_vld, rsp_dat, rsp_id, err_seq
  );
endinterface

// File: rtl/gen_pipe_arb.sv
// Round-robin arbiter feeding one fixed-latency shared pipe. A tag shift register tracks
// the owner of each transfer, so every pipe output can be routed back to the requester that issued it.
module gen_pipe_arb #(
  parameter int NREQ  = 4,
  parameter int DAT_W = 8,
  parameter int DEPTH = 4,
  parameter int ID_W  = $clog2(NREQ)
) (
  input logic          clk,
  input logic          rst,
  gen_pipe_arb_if.slave bus
);

  // Adds an offset to a requester index, wrapping modulo NREQ. NREQ need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return s[ID_W-1:0];
  endfunction

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  logic             win_found;
  logic             xfer;

  logic [DEPTH-1:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]  tag_id_q [DEPTH];
  logic [ID_W-1:0]  tag_id_d [DEPTH];
  logic             tail_vld;
  logic [ID_W-1:0]  tail_id;
  logic             rsp_hit;
  logic             seq_mis;
  logic             err_q, err_d;

  // Winner selection: scan the requesters starting at ptr and take the first one that is valid.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!win_found && bus.req_vld[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign xfer = win_found & ~rst;

  always_comb begin
    bus.req_rdy    = '0;
    bus.pipe_vld_o = xfer;
    bus.pipe_dat_o = '0;
    ptr_d          = ptr_q;
    if (xfer) begin
      bus.req_rdy[win_id] = 1'b1;
      bus.pipe_dat_o      = bus.req_dat[win_id*DAT_W +: DAT_W];
      ptr_d               = wrap_add(win_id, 1);
    end
  end

  // Stage 0 takes the new transfer, and every later stage shifts by one each cycle.
  always_comb begin
    tag_vld_d[0] = xfer;
    tag_id_d[0]  = xfer ? win_id : '0;
    for (int i = 1; i < DEPTH; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  assign tail_vld = tag_vld_q[DEPTH-1];
  assign tail_id  = tag_id_q[DEPTH-1];
  assign rsp_hit  = bus.pipe_vld_i & tail_vld & ~rst;
  assign seq_mis  = (bus.pipe_vld_i != tail_vld) & ~rst;
  assign err_d    = err_q | seq_mis;

  always_comb begin
    bus.rsp_vld = '0;
    bus.rsp_dat = '0;
    bus.rsp_id  = '0;
    if (rsp_hit) begin
      bus.rsp_vld[tail_id] = 1'b1;
      bus.rsp_dat          = bus.pipe_dat_i;
      bus.rsp_id           = tail_id;
    end
  end

  assign bus.err_seq = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tag_id_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      err_q     <= err_d;
      for (int i = 0; i < DEPTH; i++) tag_id_q[i] <= tag_id_d[i];
    end
  end

endmodule

// File: tb/tb_gen_pipe_arb.sv
// Scoreboard bench for gen_pipe_arb: a behavioural delay line loops the pipe back,
// and a round-robin model predicts grants and response routing.
module tb_gen_pipe_arb;
  localparam int NREQ  = 4;
  localparam int DAT_W = 8;
  localparam int DEPTH = 4;
  localparam int ID_W  = 2;

  typedef struct {
    int              due;
    logic [ID_W-1:0] id;
    logic [DAT_W-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pipe_rst;
  logic frc_vld;
  always #5 clk = ~clk;

  gen_pipe_arb_if #(.NREQ(NREQ), .DAT_W(DAT_W), .ID_W(ID_W)) bus ();

  gen_pipe_arb #(.NREQ(NREQ), .DAT_W(DAT_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DEPTH-1:0] pv;
  logic [DAT_W-1:0] pd [DEPTH];

  always @(posedge clk) begin
    if (pipe_rst) begin
      pv <= '0;
      for (int i = 0; i < DEPTH; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[DEPTH-2:0], bus.pipe_vld_o};
      pd[0] <= bus.pipe_dat_o;
      for (int i = 1; i < DEPTH; i++) pd[i] <= pd[i-1];
    end
  end

  assign bus.pipe_vld_i = pv[DEPTH-1] | frc_vld;
  assign bus.pipe_dat_i = frc_vld ? 8'hEE : pd[DEPTH-1];

  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  int   m_ptr = 0;
  bit   m_err = 1'b0;
  exp_t sbq[$];
  int   orph[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive the inputs, predict the outputs, check at negedge, and update the model.
  task automatic step(input logic [NREQ-1:0] v, input bit r, input bit pr, input bit f);
    logic [NREQ*DAT_W-1:0] d;
    logic [NREQ-1:0]       exp_rdy;
    logic [NREQ-1:0]       exp_rv;
    logic [ID_W-1:0]       exp_id;
    logic [DAT_W-1:0]      exp_dat;
    logic [DAT_W-1:0]      exp_pd;
    exp_t                  e;
    exp_t                  keep[$];
    int                    w;
    int                    idx;
    bit                    set_err;
    for (int i = 0; i < NREQ; i++) d[i*DAT_W +: DAT_W] = DAT_W'($urandom_range(0, 255));
    bus.req_vld = v;
    bus.req_dat = d;
    rst         = r;
    pipe_rst    = pr;
    frc_vld     = f;
    w = -1;
    if (!r) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && v[idx]) w = idx;
      end
    end
    exp_rdy = '0;
    exp_pd  = '0;
    if (w >= 0) begin
      exp_rdy[w] = 1'b1;
      exp_pd     = d[w*DAT_W +: DAT_W];
    end
    exp_rv  = '0;
    exp_id  = '0;
    exp_dat = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      if (!r) begin
        exp_rv[e.id] = 1'b1;
        exp_id       = e.id;
        exp_dat      = e.dat;
      end
    end
    set_err = f;
    if (orph.size() > 0 && orph[0] == cyc) begin
      void'(orph.pop_front());
      set_err = 1'b1;
    end
    @(negedge clk);
    check_eq("req_rdy",    32'(bus.req_rdy),    32'(exp_rdy));
    check_eq("pipe_vld_o", 32'(bus.pipe_vld_o), 32'(w >= 0));
    check_eq("pipe_dat_o", 32'(bus.pipe_dat_o), 32'(exp_pd));
    check_eq("rsp_vld",    32'(bus.rsp_vld),    32'(exp_rv));
    check_eq("rsp_id",     32'(bus.rsp_id),     32'(exp_id));
    check_eq("rsp_dat",    32'(bus.rsp_dat),    32'(exp_dat));
    check_eq("err_seq",    32'(bus.err_seq),    32'(m_err));
    if (w >= 0) begin
      e.due = cyc + DEPTH;
      e.id  = ID_W'(w);
      e.dat = exp_pd;
      sbq.push_back(e);
      m_ptr = (w + 1) % NREQ;
    end
    if (r) begin
      // Without a pipe reset, transfers still in flight come out later as orphans.
      if (!pr) begin
        foreach (sbq[i]) if (sbq[i].due > cyc) orph.push_back(sbq[i].due);
      end else begin
        orph.delete();
      end
      sbq.delete();
      keep.delete();
      m_ptr = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) m_err = 1'b0;
    else if (set_err) m_err = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step('0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    pipe_rst    = 1'b1;
    frc_vld     = 1'b0;
    bus.req_vld = '0;
    bus.req_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // Single requester: one transfer, with the response DEPTH cycles later
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);

    // Fairness: all requesters held
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);

    // Wrap and skip: move ptr to 3, then request 0101
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);

    // Idle gaps between transfers
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);

    // Random request patterns
    for (int i = 0; i < 60; i++) step(NREQ'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);

    // Sequencing error: a response with nothing in flight
    step('0, 1'b0, 1'b0, 1'b1);
    idle(3);
    do_reset();
    idle(2);

    // Mid-flight reset with the pipe reset at the same time
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(DEPTH + 2);
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 1);

    // Mid-flight reset without a pipe reset: the orphans must raise err_seq and must not be routed
    for (int i = 0; i < 2; i++) step(4'b0110, 1'b0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    idle(DEPTH + 3);
    do_reset();
    idle(2);

    check_eq("sb_drain", 32'(sbq.size()), 32'(0));
    check_eq("orph_drain", 32'(orph.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/gen_pipe_arb.md
GEN_PIPE_ARB -- requirements
Module: gen_pipe_arb

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one pipe (2..16).
REQ-002 Parameter: DAT_W, default 8, data width.
REQ-003 Parameter: DEPTH, default 4, latency of the shared pipe in cycles (>=1).
REQ-004 Parameter: ID_W, default $clog2(NREQ), requester-ID width.
REQ-005 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-006 Port: clk, in, 1, clock; all state updates on its rising edge.
REQ-007 Port: rst, in, 1, reset; synchronous, active-high.
REQ-008 Port: req_vld, in, NREQ, per-requester request valid.
REQ-009 Port: req_dat, in, NREQ*DAT_W, per-requester data; requester i occupies bits [i*DAT_W +: DAT_W].
REQ-010 Port: req_rdy, out, NREQ, one-hot grant / accept.
REQ-011 Port: pipe_dat_o, out, DAT_W, data to the shared pipe input.
REQ-012 Port: pipe_vld_o, out, 1, valid to the shared pipe input.
REQ-013 Port: pipe_dat_i, in, DAT_W, data from the shared pipe output.
REQ-014 Port: pipe_vld_i, in, 1, valid from the shared pipe output.
REQ-015 Port: rsp_vld, out, NREQ, one-hot response valid, routed to the owning requester.
REQ-016 Port: rsp_dat, out, DAT_W, response data, common to all requesters.
REQ-017 Port: rsp_id, out, ID_W, ID of the current response owner.
REQ-018 Port: err_seq, out, 1, sticky sequencing-error flag.

Function
REQ-019 Arbitration SHALL be combinational round-robin; the search starts at ptr, and the winner is the first i with req_vld[i]=1 scanning ptr, ptr+1, ... modulo NREQ.
REQ-020 req_rdy SHALL be one-hot at the winner when any req_vld is set, else all zero; req_rdy SHALL be all zero while rst=1.
REQ-021 A transfer SHALL occur when req_vld[i] & req_rdy[i]; at most one transfer per cycle, with no idle bubble between back-to-back grants.
REQ-022 pipe_vld_o SHALL be 1 on a transfer cycle and 0 otherwise; pipe_dat_o = req_dat[winner] on a transfer cycle and 0 otherwise.
REQ-023 ptr SHALL update to (winner+1) mod NREQ on a transfer cycle and hold otherwise; ptr wraps from NREQ-1 to 0.
REQ-024 A tag shift register of DEPTH stages (vld + ID) SHALL advance every cycle; stage 0 captures {pipe_vld_o, winner ID}.
REQ-025 rsp_vld[k] SHALL equal pipe_vld_i & tag_vld[DEPTH-1] & (tag_id[DEPTH-1]==k).
REQ-026 rsp_dat SHALL equal pipe_dat_i, and rsp_id SHALL equal tag_id[DEPTH-1], when a response is valid; both SHALL be 0 otherwise.
REQ-027 A response SHALL appear exactly DEPTH cycles after its transfer cycle; the block SHALL apply no backpressure on the response side.
REQ-028 err_seq SHALL set when pipe_vld_i != tag_vld[DEPTH-1], and SHALL hold until rst.
REQ-029 When pipe_vld_i=1 but tag_vld[DEPTH-1]=0, no rsp_vld bit SHALL assert.
REQ-030 Simultaneous transfer and response in the same cycle SHALL be independent, with no interaction.
REQ-031 A requester dropping req_vld without being granted SHALL be legal; it is skipped, and ptr is unaffected.

Reset
REQ-032 On rst=1 at a clk edge: ptr=0, all tag stages cleared, err_seq=0.
REQ-033 During rst=1: req_rdy=0, pipe_vld_o=0, pipe_dat_o=0, rsp_vld=0.
REQ-034 Reset mid-operation SHALL discard all in-flight tags; responses still emerging from the pipe after reset SHALL set err_seq and SHALL NOT be routed, unless the pipe is reset concurrently.

Verification
REQ-035 Single requester: NREQ=4, DEPTH=4, req_vld=0001, data 0x5A at T0 -> req_rdy=0001 at T0, pipe_vld_o=1 with 0x5A at T0; with the pipe looped back, rsp_vld=0001, rsp_dat=0x5A, rsp_id=0 at T4.
REQ-036 Fairness: req_vld=1111 held 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; responses for IDs 0..3 at cycles 4..11 in the same order.
REQ-037 Wrap and skip: ptr=3, req_vld=0101 -> grant 0, then ptr=1; next cycle grant 2, then ptr=3.
REQ-038 Sequencing error: force pipe_vld_i=1 while no tag is in flight -> rsp_vld=0000, err_seq=1 and stays 1 until rst.
REQ-039 Mid-flight reset: issue 3 transfers, assert rst for 1 cycle with the pipe also reset -> rsp_vld stays 0000, err_seq=0, ptr=0.
REQ-040 Idle gaps: alternate req_vld=0010 and 0000 every cycle -> pipe_vld_o toggles, and each response arrives exactly 4 cycles after its transfer.
